// File: rtl/lagrange_interp_pkg.sv
// Shared definitions for the Lagrange interpolator.
//   - state_t     : controller states
//   - fnbits      : field element width (from `F_NBITS)
//   - fprime      : field modulus (from `F_PRIME)
//   - mul_lat     : field multiplier latency, en to ready_pulse (cycles)
//   - cnt_width() : width of the i/k term counters for a given npoints
//   - mod_add()   : single-cycle modular addition of two reduced operands
`ifndef F_NBITS
`define F_NBITS 16
`endif
`ifndef F_PRIME
`define F_PRIME 65521
`endif

package lagrange_interp_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    WAIT = 3'd2,
    ACC  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int fnbits = `F_NBITS;
  localparam logic [fnbits-1:0] fprime = fnbits'(`F_PRIME);
  localparam int mul_lat = 3;
  localparam int max_points = 16;

  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Operands are already < p, so one conditional subtract suffices.
  function automatic logic [fnbits-1:0] mod_add(input logic [fnbits-1:0] a,
                                                input logic [fnbits-1:0] b);
    logic [fnbits:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, fprime}) s = s - {1'b0, fprime};
    return s[fnbits-1:0];
  endfunction

endpackage

// File: rtl/field_multiplier.sv
// Multi-cycle modular multiplier c = a*b mod p.
//   clk, rstb   : clock, asynchronous active-low reset
//   en          : start, accepted while ready=1; a/b sampled then
//   ready       : idle
//   ready_pulse : one-cycle pulse mul_lat cycles after the accepted en
//   c           : product, held until the next accepted en
module field_multiplier
  import lagrange_interp_pkg::*;
(
  input  logic              clk,
  input  logic              rstb,
  input  logic              en,
  input  logic [fnbits-1:0] a,
  input  logic [fnbits-1:0] b,
  output logic              ready_pulse,
  output logic              ready,
  output logic [fnbits-1:0] c
);
  logic       busy;
  logic [3:0] cnt;
  logic [2*fnbits-1:0] prod;

  assign prod  = a * b;
  assign ready = !busy;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      busy        <= 1'b0;
      cnt         <= '0;
      ready_pulse <= 1'b0;
    end else begin
      ready_pulse <= 1'b0;
      if (en && !busy) begin
        busy <= 1'b1;
        cnt  <= 4'(mul_lat - 1);
      end else if (busy) begin
        if (cnt == 4'd1) begin
          busy        <= 1'b0;
          ready_pulse <= 1'b1;
        end
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en && !busy) c <= fnbits'(prod % {{fnbits{1'b0}}, fprime});
  end
endmodule

// File: rtl/lagrange_coeffs.sv
// Constant Lagrange coefficient table for nodes 0..npoints-1.
//   idx : evaluation index i
//   kdx : coefficient index k-1 (table holds the x^1..x^(npoints-1) terms)
//   l   : coefficient of x^(kdx+1) in the i-th Lagrange basis polynomial, mod p
// The table is computed at elaboration; only the read mux is hardware.
module lagrange_coeffs
  import lagrange_interp_pkg::*;
#(
  parameter int npoints = 3,
  parameter int cw      = 2
) (
  input  logic [cw-1:0]     idx,
  input  logic [cw-1:0]     kdx,
  output logic [fnbits-1:0] l
);
  localparam int nterm = npoints * (npoints - 1);
  localparam logic [63:0] p64 = 64'(fprime);

  function automatic logic [63:0] powmod(input logic [63:0] b, input logic [63:0] e);
    logic [63:0] r, x;
    r = 64'd1;
    x = b;
    for (int n = 0; n < 64; n++) begin
      if (e[n]) r = (r * x) % p64;
      x = (x * x) % p64;
    end
    return r;
  endfunction

  // Expand prod_{m!=i}(x-m) and scale by the inverse of prod_{m!=i}(i-m).
  function automatic logic [nterm*fnbits-1:0] build_tbl();
    logic [nterm*fnbits-1:0]    t;
    logic [(max_points+1)*64-1:0] poly;
    logic [63:0] den, inv, pm;
    int deg;
    t = '0;
    for (int pi = 0; pi < npoints; pi++) begin
      poly        = '0;
      poly[63:0]  = 64'd1;
      den         = 64'd1;
      deg         = 0;
      for (int m = 0; m < npoints; m++) begin
        if (m != pi) begin
          pm = (p64 - 64'(m)) % p64;
          for (int d = deg + 1; d >= 1; d--)
            poly[d*64 +: 64] = (poly[(d-1)*64 +: 64] + pm * poly[d*64 +: 64]) % p64;
          poly[63:0] = (pm * poly[63:0]) % p64;
          deg++;
          den = (den * ((64'(pi) + p64 - 64'(m)) % p64)) % p64;
        end
      end
      inv = powmod(den, p64 - 64'd2);
      for (int j = 0; j < npoints - 1; j++)
        t[(pi*(npoints-1)+j)*fnbits +: fnbits] =
          fnbits'((poly[(j+1)*64 +: 64] * inv) % p64);
    end
    return t;
  endfunction

  localparam logic [nterm*fnbits-1:0] tbl = build_tbl();

  assign l = tbl[(32'(idx)*(npoints-1) + 32'(kdx))*fnbits +: fnbits];
endmodule

// File: rtl/lagrange_interp_seq.sv
// Sequential Lagrange interpolator: evaluations y[i]=P(i) -> coefficients c[k].
//   clk, rstb   : clock, asynchronous active-low reset
//   en          : start, accepted only while ready=1 (yvals captured then)
//   yvals       : y[0..npoints-1], element i at [i*fnbits +: fnbits]
//   cvals       : c[0..npoints-1], same packing; holds last result between runs
//   ready       : idle (IDLE or DONE)
//   ready_pulse : one cycle on completion, first cycle cvals is final
// Optional macro LAGRANGE_SKIP_ZERO_EN: terms with y[i]==0 or L[i][k-1]==0 are
// skipped in one cycle without starting the multiplier.
module lagrange_interp_seq
  import lagrange_interp_pkg::*;
#(
  parameter int npoints = 3
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      en,
  input  logic [npoints*fnbits-1:0] yvals,
  output logic [npoints*fnbits-1:0] cvals,
  output logic                      ready,
  output logic                      ready_pulse
);
  localparam int cw = cnt_width(npoints);
  localparam logic [cw-1:0] last = cw'(npoints - 1);

  state_t state, nxt_state;
  logic [cw-1:0] i, k, kdx, nxt_i, nxt_k;
  logic [npoints*fnbits-1:0] y_reg;
  logic [fnbits-1:0] y_cur, lcoef, c_cur, prod;
  logic mul_en, mul_rp, mul_rdy, skip, start;

  assign ready       = (state == IDLE) || (state == DONE);
  assign ready_pulse = (state == DONE);
  assign start       = ready && en;
  assign kdx         = k - cw'(1);
  assign y_cur       = y_reg[32'(i)*fnbits +: fnbits];
  assign c_cur       = cvals[32'(k)*fnbits +: fnbits];

`ifdef LAGRANGE_SKIP_ZERO_EN
  assign skip = (y_cur == '0) || (lcoef == '0);
`else
  assign skip = 1'b0;
`endif

  assign mul_en = (state == MUL) && !skip && mul_rdy;

  lagrange_coeffs #(.npoints(npoints), .cw(cw)) u_coeffs (
    .idx (i),
    .kdx (kdx),
    .l   (lcoef)
  );

  field_multiplier u_mul (
    .clk         (clk),
    .rstb        (rstb),
    .en          (mul_en),
    .a           (y_cur),
    .b           (lcoef),
    .ready_pulse (mul_rp),
    .ready       (mul_rdy),
    .c           (prod)
  );

  // Term sequencing: i inner, k outer; after the last term go to DONE.
  always_comb begin
    nxt_i     = i + cw'(1);
    nxt_k     = k;
    nxt_state = MUL;
    if (i == last) begin
      nxt_i = '0;
      if (k == last) nxt_state = DONE;
      else           nxt_k     = k + cw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (start) y_reg <= yvals;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      i     <= '0;
      k     <= '0;
      cvals <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // c[0] is y[0] directly; only c[1..] need accumulation.
            cvals <= {{((npoints-1)*fnbits){1'b0}}, yvals[fnbits-1:0]};
            i     <= '0;
            k     <= cw'(1);
            state <= MUL;
          end else begin
            state <= IDLE;
          end
        end
        MUL: begin
          if (skip) begin
            i     <= nxt_i;
            k     <= nxt_k;
            state <= nxt_state;
          end else if (mul_rdy) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mul_rp) state <= ACC;
        end
        ACC: begin
          cvals[32'(k)*fnbits +: fnbits] <= mod_add(c_cur, prod);
          i     <= nxt_i;
          k     <= nxt_k;
          state <= nxt_state;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
